peripheral_mpram_arbiter: RTL

Round-robin arbiter that shares one single-port MPRAM (16-bit, byte-writable, low-active chip/write enables) between `NPORTS` requesters. It sits directly in front of `peripheral_mpram_bb`, owns its `ram_*` pins, and returns read data with a per-port valid strobe. An optional lock lets one requester hold the RAM for atomic read-modify-write sequences.

---
 rtl/peripheral_mpram_pkg.sv | 25 ++
 rtl/peripheral_mpram_arbiter_if.sv | 38 +++
 rtl/peripheral_mpram_rr_pick.sv | 44 ++++
 rtl/peripheral_mpram_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/peripheral_mpram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_mpram_pkg
// Description : Shared constants and types for the MPRAM round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package peripheral_mpram_pkg;

    localparam int unsigned RAM_DW     = 16;
    localparam logic [1:0]  WEN_READ   = 2'b11;
    localparam logic [1:0]  WEN_IDLE   = 2'b11;
    localparam int unsigned NPORTS_MAX = 8;

    // Wide enough for the largest supported port count.
    typedef logic [$clog2(NPORTS_MAX)-1:0] rr_ptr_t;

    function automatic rr_ptr_t rr_next(input rr_ptr_t idx, input int unsigned nports);
        if ((32'(idx) + 32'd1) >= nports) begin
            return '0;
        end
        return idx + rr_ptr_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_mpram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_mpram_arbiter_if
// Description : Requester bundle plus RAM command/data pins of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface peripheral_mpram_arbiter_if #(
    parameter int unsigned NPORTS   = 4,
    parameter int unsigned ADDR_MSB = 6
);
    import peripheral_mpram_pkg::*;

    logic [NPORTS-1:0]                 req;
    logic [NPORTS-1:0][ADDR_MSB-1:0]   req_addr;
    logic [NPORTS-1:0][RAM_DW-1:0]     req_din;
    logic [NPORTS-1:0][1:0]            req_wen;
    logic [NPORTS-1:0]                 req_lock;
    logic [NPORTS-1:0]                 gnt;
    logic [NPORTS-1:0]                 rvalid;
    logic [RAM_DW-1:0]                 rdata;
    logic [ADDR_MSB-1:0]               ram_addr;
    logic [RAM_DW-1:0]                 ram_din;
    logic                              ram_cen;
    logic [1:0]                        ram_wen;
    logic [RAM_DW-1:0]                 ram_dout;

    modport slave (
        input  req, req_addr, req_din, req_wen, req_lock, ram_dout,
        output gnt, rvalid, rdata, ram_addr, ram_din, ram_cen, ram_wen
    );

    modport master (
        output req, req_addr, req_din, req_wen, req_lock, ram_dout,
        input  gnt, rvalid, rdata, ram_addr, ram_din, ram_cen, ram_wen
    );

endinterface
`default_nettype wire

// File: rtl/peripheral_mpram_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_mpram_rr_pick
// Description : Rotate-priority encoder: first requester at or after i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_mpram_rr_pick
    import peripheral_mpram_pkg::*;
#(
    parameter int unsigned NPORTS = 4
) (
    input  wire logic [NPORTS-1:0] i_req,
    input  wire rr_ptr_t           i_ptr,
    output logic [NPORTS-1:0]      o_gnt,
    output rr_ptr_t                o_idx,
    output logic                   o_valid
);

    logic [NPORTS-1:0] w_rot;
    int unsigned       w_pos;

    // Bit k of w_rot is port (i_ptr + k) mod NPORTS.
    assign w_rot = NPORTS'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                w_pos   = 32'(i_ptr) + 32'(k);
            end
        end
        if (w_pos >= NPORTS) begin
            w_pos = w_pos - NPORTS;
        end
        o_idx = rr_ptr_t'(w_pos);
        for (int j = 0; j < NPORTS; j++) begin
            o_gnt[j] = o_valid && (o_idx == rr_ptr_t'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/peripheral_mpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_mpram_arbiter
// Description : Round-robin arbiter sharing one single-port MPRAM between
//               NPORTS requesters; PERIPHERAL_MPRAM_LOCK_EN adds owner lock.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_mpram_arbiter
    import peripheral_mpram_pkg::*;
#(
    parameter int unsigned NPORTS   = 4,
    parameter int unsigned ADDR_MSB = 6,
    parameter int unsigned LOCK_MAX = 15
) (
    input  wire logic                  ram_clk,
    input  wire logic                  ram_rst,
    peripheral_mpram_arbiter_if.slave  bus
);

    rr_ptr_t             r_ptr;
    rr_ptr_t             r_rd_idx;
    logic                r_rd_pend;

    logic [NPORTS-1:0]   w_req_eff;
    logic [NPORTS-1:0]   w_gnt;
    rr_ptr_t             w_idx;
    logic                w_valid;
    logic                w_is_read;
    logic [ADDR_MSB-1:0] w_addr;

`ifdef PERIPHERAL_MPRAM_LOCK_EN
    localparam int unsigned c_CNT_W = $clog2(LOCK_MAX + 1);

    logic               r_own_vld;
    rr_ptr_t            r_owner;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic               w_lock_sel;

    assign w_lock_sel = |(w_gnt & bus.req_lock);

    // An owner masks every other requester, even while it is not requesting.
    always_comb begin
        w_req_eff = bus.req;
        if (r_own_vld) begin
            for (int j = 0; j < NPORTS; j++) begin
                if (r_owner != rr_ptr_t'(j)) begin
                    w_req_eff[j] = 1'b0;
                end
            end
        end
        if (ram_rst) begin
            w_req_eff = '0;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            r_own_vld  <= 1'b0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else if (w_valid) begin
            if (w_lock_sel && ((32'(r_lock_cnt) + 32'd1) < LOCK_MAX)) begin
                r_own_vld  <= 1'b1;
                r_owner    <= w_idx;
                r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
            end else begin
                r_own_vld  <= 1'b0;
                r_lock_cnt <= '0;
            end
        end
    end
`else
    wire w_unused_lock = ^{bus.req_lock, 1'(LOCK_MAX)};

    assign w_req_eff = ram_rst ? '0 : bus.req;
`endif

    peripheral_mpram_rr_pick #(
        .NPORTS (NPORTS)
    ) u_pick (
        .i_req   (w_req_eff),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign bus.gnt      = w_gnt;
    assign bus.ram_addr = w_addr;

    always_comb begin
        bus.ram_cen = 1'b1;
        bus.ram_wen = WEN_IDLE;
        bus.ram_din = '0;
        w_addr      = '0;
        w_is_read   = 1'b0;
        for (int j = 0; j < NPORTS; j++) begin
            if (w_gnt[j]) begin
                bus.ram_cen = 1'b0;
                bus.ram_wen = bus.req_wen[j];
                bus.ram_din = bus.req_din[j];
                w_addr      = bus.req_addr[j];
                w_is_read   = (bus.req_wen[j] == WEN_READ);
            end
        end
    end

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            r_ptr     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_idx  <= '0;
        end else begin
            r_rd_pend <= w_is_read;
            if (w_is_read) begin
                r_rd_idx <= w_idx;
            end
            if (w_valid) begin
                r_ptr <= rr_next(w_idx, NPORTS);
            end
        end
    end

    // Gated by reset so a read granted just before reset never reports valid.
    always_comb begin
        bus.rvalid = '0;
        bus.rdata  = '0;
        if (r_rd_pend && !ram_rst) begin
            bus.rdata = bus.ram_dout;
            for (int j = 0; j < NPORTS; j++) begin
                bus.rvalid[j] = (r_rd_idx == rr_ptr_t'(j));
            end
        end
    end

endmodule
`default_nettype wire
